// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: PC, instruction register and req/ack word reads from instruction memory.
// Optional fetch-timeout watchdog with sticky error and HALT state: define SISC_FETCH_TIMEOUT_EN.
module sisc_fetch #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic [AW-1:0] imem_addr,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [31:0]   imem_data,
    output logic [31:0]   ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          br_taken,
    input  logic          br_rel,
    input  logic [15:0]   br_imm,
    output logic [AW-1:0] pc,
    output logic          fetch_err
);

`ifdef SISC_FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_reg;
    logic          fetch_err_reg;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

    state_t        state_reg;
    logic [AW-1:0] pc_reg;
    logic [31:0]   ir_reg;
    logic          ir_valid_reg;
    logic          imem_req_reg;

    logic [AW-1:0] imm_sext;
    logic [AW-1:0] imm_zext;
    logic [AW-1:0] br_target;

    // Fit the 16-bit immediate to the PC width in both directions.
    generate
        if (AW > 16) begin : g_imm_wide
            assign imm_sext = {{(AW-16){br_imm[15]}}, br_imm};
            assign imm_zext = {{(AW-16){1'b0}}, br_imm};
        end else if (AW == 16) begin : g_imm_equal
            assign imm_sext = br_imm;
            assign imm_zext = br_imm;
        end else begin : g_imm_narrow
            assign imm_sext = br_imm[AW-1:0];
            assign imm_zext = br_imm[AW-1:0];
        end
    endgenerate

    // pc already points past the consumed instruction when HOLD evaluates this.
    assign br_target = br_rel ? (pc_reg + imm_sext) : imm_zext;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            ir_reg        <= 32'h0;
            ir_valid_reg  <= 1'b0;
            imem_req_reg  <= 1'b0;
`ifdef SISC_FETCH_TIMEOUT_EN
            cnt_reg       <= '0;
            fetch_err_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    imem_req_reg <= 1'b1;
                    state_reg    <= REQ;
`ifdef SISC_FETCH_TIMEOUT_EN
                    cnt_reg      <= '0;
`endif
                end
                REQ: begin
                    if (imem_ack) begin
                        ir_reg       <= imem_data;
                        ir_valid_reg <= 1'b1;
                        pc_reg       <= pc_reg + 1'b1;
                        imem_req_reg <= 1'b0;
                        state_reg    <= HOLD;
                    end
`ifdef SISC_FETCH_TIMEOUT_EN
                    // An ack on the final allowed cycle takes priority over the timeout.
                    else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        imem_req_reg  <= 1'b0;
                        fetch_err_reg <= 1'b1;
                        state_reg     <= HALT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid_reg <= 1'b0;
                        imem_req_reg <= 1'b1;
                        state_reg    <= REQ;
                        if (br_taken) begin
                            pc_reg <= br_target;
                        end
`ifdef SISC_FETCH_TIMEOUT_EN
                        cnt_reg <= '0;
`endif
                    end
                end
`ifdef SISC_FETCH_TIMEOUT_EN
                HALT: begin
                    ir_valid_reg <= 1'b0;
                    imem_req_reg <= 1'b0;
                end
`endif
                default: begin
                    state_reg    <= IDLE;
                    imem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_reg;
    assign imem_addr = pc_reg;
    assign imem_req  = imem_req_reg;
    assign ir        = ir_reg;
    assign ir_valid  = ir_valid_reg;
`ifdef SISC_FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_reg;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch: fetch timing, stall, branches, PC wrap and asynchronous reset.
// The watchdog section runs only when SISC_FETCH_TIMEOUT_EN is defined.
module tb_sisc_fetch;

    logic        clk;
    logic        rst_f;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        br_taken;
    logic        br_rel;
    logic [15:0] br_imm;
    logic [15:0] pc;
    logic        fetch_err;

    // Second instance starting at the top of the address space, with zero-wait memory.
    logic [15:0] w_addr;
    logic        w_req;
    logic        w_ack;
    logic [31:0] w_ir;
    logic        w_valid;
    logic [15:0] w_pc;
    logic        w_err;
    logic        w_ready;
    logic        w_br_taken;
    logic        w_br_rel;
    logic [15:0] w_br_imm;
    logic [31:0] w_data;

    int total = 0;
    int bad   = 0;

    sisc_fetch #(.AW(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst_f(rst_f),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .br_taken(br_taken), .br_rel(br_rel), .br_imm(br_imm),
        .pc(pc), .fetch_err(fetch_err)
    );

    sisc_fetch #(.AW(16), .RESET_PC(16'hFFFF), .TIMEOUT(15)) dut_w (
        .clk(clk), .rst_f(rst_f),
        .imem_addr(w_addr), .imem_req(w_req), .imem_ack(w_ack), .imem_data(w_data),
        .ir(w_ir), .ir_valid(w_valid), .ir_ready(w_ready),
        .br_taken(w_br_taken), .br_rel(w_br_rel), .br_imm(w_br_imm),
        .pc(w_pc), .fetch_err(w_err)
    );

    assign w_ack = w_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_f      = 1'b0;
        imem_ack   = 1'b0;
        imem_data  = 32'h0;
        ir_ready   = 1'b0;
        br_taken   = 1'b0;
        br_rel     = 1'b0;
        br_imm     = 16'h0;
        w_ready    = 1'b1;
        w_br_taken = 1'b0;
        w_br_rel   = 1'b0;
        w_br_imm   = 16'h0;
        w_data     = 32'h0;

        tick();
        tick();
        chk("rst_pc",       32'(pc),        32'h0);
        chk("rst_ir",       ir,             32'h0);
        chk("rst_valid",    32'(ir_valid),  32'h0);
        chk("rst_req",      32'(imem_req),  32'h0);
        chk("rst_err",      32'(fetch_err), 32'h0);
        chk("rst_w_pc",     32'(w_pc),      32'hFFFF);

        // Zero-wait fetches: addresses 0,1,2 every two cycles.
        rst_f = 1'b1;
        tick();
        chk("f0_req",       32'(imem_req),  32'h1);
        chk("f0_addr",      32'(imem_addr), 32'h0);
        chk("w_addr0",      32'(w_addr),    32'hFFFF);
        imem_ack = 1'b1; imem_data = 32'h1234_5678; ir_ready = 1'b1;
        tick();
        chk("f0_ir",        ir,             32'h1234_5678);
        chk("f0_valid",     32'(ir_valid),  32'h1);
        chk("f0_pc",        32'(pc),        32'h1);
        chk("f0_req_low",   32'(imem_req),  32'h0);
        chk("w_wrap_pc",    32'(w_pc),      32'h0);
        imem_ack = 1'b0;
        tick();
        chk("f1_addr",      32'(imem_addr), 32'h1);
        chk("f1_req",       32'(imem_req),  32'h1);
        chk("f1_valid",     32'(ir_valid),  32'h0);
        chk("w_addr1",      32'(w_addr),    32'h0);
        imem_ack = 1'b1; imem_data = 32'hA000_0001;
        tick();
        chk("f1_ir",        ir,             32'hA000_0001);
        imem_ack = 1'b0;
        tick();
        chk("f2_addr",      32'(imem_addr), 32'h2);

        // Three-cycle ack latency, then consumer stalls for five cycles.
        ir_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lat_addr", 32'(imem_addr), 32'h2);
            chk("lat_req",  32'(imem_req),  32'h1);
        end
        imem_ack = 1'b1; imem_data = 32'hA000_0002;
        tick();
        chk("lat_ir",       ir,             32'hA000_0002);
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
            end else begin
                imem_ack = 1'b0;
            end
            tick();
            chk("hold_valid", 32'(ir_valid), 32'h1);
            chk("hold_req",   32'(imem_req), 32'h0);
            chk("hold_pc",    32'(pc),       32'h3);
            chk("hold_ir",    ir,            32'hA000_0002);
        end
        imem_ack = 1'b0;

        // Absolute branch to 0x0010, then a branch held during REQ must be ignored.
        ir_ready = 1'b1; br_taken = 1'b1; br_rel = 1'b0; br_imm = 16'h0010;
        tick();
        chk("abs10_addr",   32'(imem_addr), 32'h10);
        imem_ack = 1'b1; imem_data = 32'hA000_0010; br_imm = 16'h0040;
        tick();
        chk("req_br_ign",   32'(pc),        32'h11);
        imem_ack = 1'b0; br_rel = 1'b1; br_imm = 16'hFFFE;
        tick();
        chk("rel_addr",     32'(imem_addr), 32'h0F);
        imem_ack = 1'b1; imem_data = 32'hA000_000F; br_taken = 1'b0;
        tick();
        chk("rel_pc",       32'(pc),        32'h10);
        imem_ack = 1'b0; br_taken = 1'b1; br_rel = 1'b0; br_imm = 16'h0040;
        tick();
        chk("abs40_addr",   32'(imem_addr), 32'h40);
        chk("ir_kept",      ir,             32'hA000_000F);
        br_taken = 1'b0;

        // Asynchronous reset while a request is outstanding.
        chk("pre_rst_req",  32'(imem_req),  32'h1);
        #2;
        rst_f = 1'b0;
        #1;
        chk("arst_req",     32'(imem_req),  32'h0);
        chk("arst_valid",   32'(ir_valid),  32'h0);
        chk("arst_ir",      ir,             32'h0);
        chk("arst_pc",      32'(pc),        32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_data = 32'hBAD0_BAD0; rst_f = 1'b1;
        tick();
        chk("late_ack_ir",  ir,             32'h0);
        chk("late_ack_vld", 32'(ir_valid),  32'h0);
        chk("late_ack_req", 32'(imem_req),  32'h1);
        imem_ack = 1'b0;

`ifdef SISC_FETCH_TIMEOUT_EN
        // Memory never acks: error after 15 REQ cycles, sticky until reset.
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("to_pre_err",   32'(fetch_err), 32'h0);
        chk("to_pre_req",   32'(imem_req),  32'h1);
        tick();
        chk("to_err",       32'(fetch_err), 32'h1);
        chk("to_req",       32'(imem_req),  32'h0);
        imem_ack = 1'b1; imem_data = 32'h5555_AAAA; ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_err",   32'(fetch_err), 32'h1);
            chk("halt_req",   32'(imem_req),  32'h0);
            chk("halt_valid", 32'(ir_valid),  32'h0);
        end
        imem_ack = 1'b0;
        // Ack on the fifteenth REQ cycle wins over the timeout.
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        imem_ack = 1'b1; imem_data = 32'h0F0F_0F0F;
        tick();
        chk("to15_ir",      ir,             32'h0F0F_0F0F);
        chk("to15_err",     32'(fetch_err), 32'h0);
        imem_ack = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Instruction fetch stage for the SISC processor; sits directly upstream of the control/datapath and produces the 32-bit `ir` it consumes.
- Holds the program counter and the instruction register.
- Issues word reads to instruction memory over a req/ack handshake.
- Applies branch redirects when the control unit accepts the current instruction.

Parameters:
- AW, 16: PC / instruction-memory word-address width.
- RESET_PC, 0: PC value loaded on reset.
- TIMEOUT, 15: max REQ cycles before a fetch error (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_f  in  1  asynchronous active-low reset.
- imem_addr  out  AW  word address to instruction memory; equals pc.
- imem_req  out  1  read request, registered.
- imem_ack  in  1  memory returns valid data this cycle.
- imem_data  in  32  instruction word; sampled when imem_ack=1.
- ir  out  32  instruction register to control/datapath.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  control accepts ir this cycle.
- br_taken  in  1  redirect; qualified by ir_valid & ir_ready.
- br_rel  in  1  1 = PC-relative target, 0 = absolute.
- br_imm  in  16  branch offset or absolute target.
- pc  out  AW  current program counter.
- fetch_err  out  1  sticky fetch-timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset (rst_f=0, asynchronous): pc=RESET_PC, ir=32'h0, ir_valid=0, imem_req=0, fetch_err=0, state=IDLE. The in-flight request is abandoned immediately; a late ack after reset release is ignored unless the FSM is in REQ.
- State IDLE: on the next clk go to REQ and set imem_req=1.
- State REQ:
  - imem_req=1 and imem_addr=pc held stable until ack.
  - On imem_ack=1: ir<=imem_data, ir_valid<=1, pc<=pc+1, imem_req<=0, go to HOLD.
  - Ack may arrive in the first REQ cycle.
- State HOLD:
  - ir and ir_valid held; no request issued.
  - On ir_ready=1 with br_taken=0: ir_valid<=0, imem_req<=1, go to REQ.
  - On ir_ready=1 with br_taken=1: same as above, and pc<=target.
- Branch target:
  - br_rel=1: pc + sign-extended br_imm, where pc is already incremented (relative to the next instruction).
  - br_rel=0: br_imm zero-extended or truncated to AW.
  - br_taken/br_rel/br_imm are ignored in all other cycles.
- imem_ack outside REQ is ignored. ir_ready with ir_valid=0 is ignored.
- Arithmetic: pc increment and relative add are modulo 2^AW; pc=2^AW-1 increments to 0.
- Throughput: minimum 2 cycles per instruction (REQ with same-cycle ack, then HOLD with ready).
- ir changes only on an ack in REQ; it keeps its old value after being consumed.

Optional Feature:
- Macro: SISC_FETCH_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT: imem_req<=0, fetch_err<=1 (sticky until reset), go to state HALT.
  - HALT: ir_valid=0; no requests; ack and ready ignored. Exit only by reset.
  - An ack in the same cycle the counter reaches TIMEOUT wins: normal load, no error.
- Undefined: no counter and no HALT state; REQ waits indefinitely; fetch_err is constant 0.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), mem[0]=32'h1234_5678, ir_ready=1 → ir=32'h1234_5678 with ir_valid=1 in cycle 2; pc=1; imem_addr sequence 0,1,2 at 2 cycles/instruction.
- 3-cycle ack latency, ir_ready held 0 for 5 cycles → imem_addr stable during REQ; ir_valid stays 1, imem_req stays 0 until ready; no pc change while holding.
- Relative branch: at pc after fetch = 0x0011, br_taken=1, br_rel=1, br_imm=16'hFFFE with ready → next imem_addr=0x000F. Absolute branch, br_imm=0x0040 → next imem_addr=0x0040. br_taken asserted in REQ → ignored.
- Wrap: RESET_PC=16'hFFFF → after one fetch pc=0x0000 and next imem_addr=0x0000.
- Reset mid-REQ: assert rst_f=0 while imem_req=1 → imem_req, ir_valid, and ir drop to 0 without waiting for clk; pc=RESET_PC; an ack in the reset-release cycle does not load ir.
- With SISC_FETCH_TIMEOUT_EN and TIMEOUT=15, memory never acks → fetch_err=1 and imem_req=0 after 15 REQ cycles; both stay so until reset. Ack on cycle 15 → normal load, fetch_err=0.
